display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving the clock cycles each digit stays selected (1 kHz digit rate at 100 MHz).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port value  input  14  unsigned binary magnitude to display.
REQ-005 The block SHALL have port negative  input  1  sign flag sampled with value.
REQ-006 The block SHALL have port load  input  1  single-cycle request to capture value/negative.
REQ-007 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse when new digits are committed.
REQ-009 The block SHALL have port digit  output  4  code for the segment decoder: 0-9, or 10 = dash.
REQ-010 The block SHALL have port enable  output  4  active-low one-hot anode select, bit 0 = rightmost digit.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and COMMIT.
REQ-012 IDLE with load=1: capture value and negative, clear the BCD shift register, set shift count 0, go to SHIFT, drive busy=1 from the next cycle.
REQ-013 Load SHALL be ignored in SHIFT and COMMIT; no queueing.
REQ-014 SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift the {BCD, binary} register left by one.
REQ-015 SHIFT SHALL last exactly 14 cycles, then go to COMMIT.
REQ-016 COMMIT: write the four display registers in one edge, pulse done for one cycle, set busy=0, return to IDLE.
REQ-017 Latency SHALL be fixed: load sampled at edge N gives done high after edge N+16, with digits committed at the same edge.
REQ-018 Error, value >9999: all four display registers SHALL be 10 (dash).
REQ-019 Error, negative=1 with value >999: all four display registers SHALL be 10 (dash).
REQ-020 Normal, negative=1 with value <=999: display register 3 (leftmost) SHALL be 10; registers 2..0 SHALL hold the hundreds, tens and units digits.
REQ-021 Normal, negative=0: registers 3..0 SHALL hold thousands..units; leading zeros are shown, not blanked.
REQ-022 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on each wrap the scan index advances 0->1->2->3->0.
REQ-023 enable SHALL be registered: index 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111; exactly one bit is low at any time after reset.
REQ-024 digit SHALL be registered from the display register at the current index, so it changes on the same edge as enable.
REQ-025 Scanning SHALL run continuously and independently of conversion; a commit is visible from the next digit-output update.
REQ-026 REFRESH_DIV=1 SHALL advance the scan index every cycle.

Reset
REQ-027 While rst_n=0 at a clock edge: FSM=IDLE, busy=0, done=0, display registers=0, refresh counter=0, scan index=0, digit=0, enable=1111 (all off).
REQ-028 Reset SHALL take priority over load in the same cycle.
REQ-029 Reset during SHIFT or COMMIT SHALL abort the conversion: no done pulse, display registers cleared.
REQ-030 On the first edge with rst_n=1, enable SHALL become 1110 and digit SHALL become display register 0.

Structure
REQ-031 Shared package SHALL hold DIGIT_DASH=10, MAX_UNSIGNED=9999, MAX_NEG=999, the four anode patterns and the FSM state encoding.
REQ-032 A sub-module bcd_converter (sequential double-dabble: start, 14-bit in, 16-bit BCD out, done) SHALL hold REQ-014/REQ-015.
REQ-033 Sign/error override, refresh counter and anode scanning SHALL stay in display_scanner.

Verification (REFRESH_DIV=4 unless stated)
REQ-034 Reset, then run 16 cycles -> enable sequence 1110,1101,1011,0111, each held 4 cycles; digit=0 throughout.
REQ-035 value=1234, negative=0, load pulse -> busy high 15 cycles, done exactly 16 edges after load; scan shows digits 4,3,2,1 for indices 0..3.
REQ-036 value=57, negative=1 -> digits 7,5,0,10; then value=1000, negative=1 -> all 10; then value=12000 -> all 10.
REQ-037 value=9999 loaded; second load (value=1) 5 cycles later -> ignored, single done, display 9,9,9,9.
REQ-038 rst_n low at SHIFT cycle 7 of value=4321 -> no done pulse, enable=1111 during reset, digits 0 after release.
REQ-039 REFRESH_DIV=1, value=8 -> enable rotates every cycle; done/busy timing identical to REQ-035.

Source files
------------

// File: rtl/display_scanner_pkg.sv
// Shared constants, state encoding and helpers for the multiplexed display scanner.
package display_scanner_pkg;

  localparam int BIN_WIDTH    = 14;
  localparam int BCD_WIDTH    = 16;
  localparam int SHIFT_CYCLES = 14;

  localparam logic [3:0]  DIGIT_DASH   = 4'd10;
  localparam logic [13:0] MAX_UNSIGNED = 14'd9999;
  localparam logic [13:0] MAX_NEG      = 14'd999;

  // Active-low anode patterns, bit 0 is the rightmost digit.
  localparam logic [3:0] ANODE_0   = 4'b1110;
  localparam logic [3:0] ANODE_1   = 4'b1101;
  localparam logic [3:0] ANODE_2   = 4'b1011;
  localparam logic [3:0] ANODE_3   = 4'b0111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Conversion FSM encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Four display registers, element 3 is the leftmost digit.
  typedef logic [3:0][3:0] digits_t;

  // Double-dabble correction: every BCD nibble of 5 or more gets 3 added
  // so that the following left shift carries correctly into the next decade.
  function automatic logic [BCD_WIDTH-1:0] dabble_adjust(input logic [BCD_WIDTH-1:0] bcd);
    logic [BCD_WIDTH-1:0] result;
    result = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        result[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return result;
  endfunction

  // Anode pattern for a given scan index.
  function automatic logic [3:0] anode_for(input logic [1:0] index);
    logic [3:0] pattern;
    case (index)
      2'd0:    pattern = ANODE_0;
      2'd1:    pattern = ANODE_1;
      2'd2:    pattern = ANODE_2;
      default: pattern = ANODE_3;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/display_scanner_bcd_converter.sv
// Sequential double-dabble converter: 14-bit binary in, four BCD digits out
// after exactly fourteen shift cycles, with a one-cycle done pulse.
module bcd_converter
  import display_scanner_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic [BCD_WIDTH-1:0] bcd_out,
  output logic                 done
);

  logic [BCD_WIDTH+BIN_WIDTH-1:0] shift_reg;
  logic [3:0]                     count;
  logic                           active;

  // Load on start, then adjust-and-shift the combined {BCD, binary} register
  // once per cycle; done pulses after the final shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      count     <= 4'd0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shift_reg <= {{BCD_WIDTH{1'b0}}, bin_in};
        count     <= 4'd0;
        active    <= 1'b1;
      end else if (active) begin
        shift_reg <= {dabble_adjust(shift_reg[BCD_WIDTH+BIN_WIDTH-1:BIN_WIDTH]),
                      shift_reg[BIN_WIDTH-1:0]} << 1;
        count     <= count + 4'd1;
        if (count == 4'(SHIFT_CYCLES - 1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign bcd_out = shift_reg[BCD_WIDTH+BIN_WIDTH-1:BIN_WIDTH];

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed display driver: converts a signed magnitude to BCD,
// applies sign/overflow dashes, and scans the digits onto a common decoder.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        negative,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit,
  output logic [3:0]  enable
);

  localparam int                CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [1:0]           state;
  logic [13:0]          cap_value;
  logic                 cap_negative;
  digits_t              disp;
  digits_t              commit_digits;
  logic                 conv_start;
  logic [BCD_WIDTH-1:0] conv_bcd;
  logic                 conv_done;
  logic [CNT_W-1:0]     refresh_count;
  logic [1:0]           scan_index;

  // The converter is started on the same edge that captures the request.
  assign conv_start = (state == ST_IDLE) && load;

  bcd_converter u_bcd_converter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (conv_start),
    .bin_in  (value),
    .bcd_out (conv_bcd),
    .done    (conv_done)
  );

  // Choose what the display registers receive at commit: all dashes on
  // overflow, a leading dash for small negatives, otherwise the plain digits.
  always_comb begin
    commit_digits = digits_t'(conv_bcd);
    if ((cap_value > MAX_UNSIGNED) || (cap_negative && (cap_value > MAX_NEG))) begin
      commit_digits = {DIGIT_DASH, DIGIT_DASH, DIGIT_DASH, DIGIT_DASH};
    end else if (cap_negative) begin
      commit_digits[3] = DIGIT_DASH;
    end
  end

  // Conversion FSM: capture in IDLE, wait for the converter in SHIFT,
  // write the display registers and pulse done in COMMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      cap_value    <= 14'd0;
      cap_negative <= 1'b0;
      disp         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            cap_value    <= value;
            cap_negative <= negative;
            busy         <= 1'b1;
            state        <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (conv_done) begin
            busy  <= 1'b0;
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          disp  <= commit_digits;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Refresh divider: each wrap moves the scan to the next digit position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_count <= '0;
      scan_index    <= 2'd0;
    end else if (refresh_count == CNT_LAST) begin
      refresh_count <= '0;
      scan_index    <= scan_index + 2'd1;
    end else begin
      refresh_count <= refresh_count + CNT_W'(1);
    end
  end

  // Registered anode and digit outputs so both change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable <= ANODE_OFF;
      digit  <= 4'd0;
    end else begin
      enable <= anode_for(scan_index);
      digit  <= disp[scan_index];
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench: one scanner with REFRESH_DIV=4 and one with
// REFRESH_DIV=1 driven by the same inputs, checked against a directed table.
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] value = 14'd0;
  logic        negative = 1'b0;
  logic        load = 1'b0;

  logic       busy4, done4, busy1, done1;
  logic [3:0] digit4, enable4, digit1, enable1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [13:0] value;
    logic        negative;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs[12];

  display_scanner #(.REFRESH_DIV(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .negative (negative),
    .load     (load),
    .busy     (busy4),
    .done     (done4),
    .digit    (digit4),
    .enable   (enable4)
  );

  display_scanner #(.REFRESH_DIV(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .negative (negative),
    .load     (load),
    .busy     (busy1),
    .done     (done1),
    .digit    (digit1),
    .enable   (enable1)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int index_of(input logic [3:0] en);
    int idx;
    case (en)
      4'b1110: idx = 0;
      4'b1101: idx = 1;
      4'b1011: idx = 2;
      4'b0111: idx = 3;
      default: idx = -1;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] pattern_of(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  // Watch both scanners for a while and check every digit position shows the
  // expected code, that one anode is active, and that the fast one rotates.
  task automatic scan_display(input string tag, input logic [15:0] expected);
    int seen4[4];
    int seen1[4];
    int bad_anode;
    int bad_rotate;
    int prev1;
    int i4;
    int i1;
    for (int i = 0; i < 4; i++) begin
      seen4[i] = -1;
      seen1[i] = -1;
    end
    bad_anode  = 0;
    bad_rotate = 0;
    prev1      = index_of(enable1);
    for (int c = 0; c < 20; c++) begin
      tick();
      i4 = index_of(enable4);
      i1 = index_of(enable1);
      if (i4 < 0 || i1 < 0) bad_anode++;
      if (i4 >= 0) seen4[i4] = int'(digit4);
      if (i1 >= 0) seen1[i1] = int'(digit1);
      if (i1 != (prev1 + 1) % 4) bad_rotate++;
      prev1 = i1;
    end
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("%s div4 digit%0d", tag, i), seen4[i], int'(expected[i*4 +: 4]));
      check_output($sformatf("%s div1 digit%0d", tag, i), seen1[i], int'(expected[i*4 +: 4]));
    end
    check_output({tag, " anode one-hot violations"}, bad_anode, 0);
    check_output({tag, " div1 rotation errors"}, bad_rotate, 0);
  endtask

  // Pulse load with a value and measure busy/done timing on both scanners;
  // optionally fire a second load while the first is still converting.
  task automatic apply_stimulus(input string tag, input logic [13:0] v, input logic n,
                                input int second_load_k);
    int busy4_n, busy1_n, pulses4, pulses1, done_at4, done_at1;
    busy4_n = 0; busy1_n = 0; pulses4 = 0; pulses1 = 0; done_at4 = -1; done_at1 = -1;
    value    = v;
    negative = n;
    load     = 1'b1;
    tick();
    load = 1'b0;
    check_output({tag, " busy after load edge"}, int'(busy4), 1);
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      if (busy4) busy4_n++;
      if (busy1) busy1_n++;
      if (done4) begin
        pulses4++;
        if (done_at4 < 0) done_at4 = k;
      end
      if (done1) begin
        pulses1++;
        if (done_at1 < 0) done_at1 = k;
      end
      if (second_load_k >= 0 && k == second_load_k) begin
        value    = 14'd1;
        negative = 1'b0;
        load     = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    check_output({tag, " div4 busy cycles"}, busy4_n, 15);
    check_output({tag, " div4 done edge"}, done_at4, 16);
    check_output({tag, " div4 done pulses"}, pulses4, 1);
    check_output({tag, " div1 busy cycles"}, busy1_n, 15);
    check_output({tag, " div1 done edge"}, done_at1, 16);
    check_output({tag, " div1 done pulses"}, pulses1, 1);
  endtask

  initial begin
    int p4;
    int p1;

    vecs[0]  = '{14'd1234,  1'b0, 16'h1234};
    vecs[1]  = '{14'd57,    1'b1, 16'hA057};
    vecs[2]  = '{14'd1000,  1'b1, 16'hAAAA};
    vecs[3]  = '{14'd12000, 1'b0, 16'hAAAA};
    vecs[4]  = '{14'd8,     1'b0, 16'h0008};
    vecs[5]  = '{14'd0,     1'b0, 16'h0000};
    vecs[6]  = '{14'd9999,  1'b0, 16'h9999};
    vecs[7]  = '{14'd10000, 1'b0, 16'hAAAA};
    vecs[8]  = '{14'd999,   1'b1, 16'hA999};
    vecs[9]  = '{14'd16383, 1'b0, 16'hAAAA};
    vecs[10] = '{14'd1,     1'b0, 16'h0001};
    vecs[11] = '{14'd0,     1'b1, 16'hA000};

    // Reset state, with load asserted to show reset wins.
    rst_n = 1'b0;
    load  = 1'b1;
    value = 14'd4321;
    tick();
    tick();
    load = 1'b0;
    tick();
    check_output("reset busy", int'(busy4), 0);
    check_output("reset done", int'(done4), 0);
    check_output("reset digit", int'(digit4), 0);
    check_output("reset enable div4", int'(enable4), int'(4'b1111));
    check_output("reset enable div1", int'(enable1), int'(4'b1111));
    check_output("reset digit div1", int'(digit1), 0);

    // Release and check the idle scan sequence.
    rst_n = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      tick();
      check_output($sformatf("idle scan enable div4 edge%0d", j), int'(enable4),
                   int'(pattern_of((j - 1) / 4)));
      check_output($sformatf("idle scan digit div4 edge%0d", j), int'(digit4), 0);
      check_output($sformatf("idle scan enable div1 edge%0d", j), int'(enable1),
                   int'(pattern_of((j - 1) % 4)));
    end
    check_output("idle busy after scan", int'(busy4), 0);

    // Table of conversions.
    for (int v = 0; v < 12; v++) begin
      apply_stimulus($sformatf("vec%0d", v), vecs[v].value, vecs[v].negative, -1);
      scan_display($sformatf("vec%0d", v), vecs[v].expected);
    end

    // A second load during SHIFT must be ignored.
    apply_stimulus("reload", 14'd1234, 1'b0, -1);
    apply_stimulus("ignore2nd", 14'd9999, 1'b0, 4);
    scan_display("ignore2nd", 16'h9999);

    // Reset in the middle of a conversion aborts it and clears the display.
    value    = 14'd4321;
    negative = 1'b0;
    load     = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    rst_n = 1'b0;
    tick();
    check_output("abort enable div4 in reset", int'(enable4), int'(4'b1111));
    check_output("abort enable div1 in reset", int'(enable1), int'(4'b1111));
    check_output("abort busy in reset", int'(busy4), 0);
    tick();
    rst_n = 1'b1;
    p4 = 0;
    p1 = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done4) p4++;
      if (done1) p1++;
    end
    check_output("abort div4 done pulses", p4, 0);
    check_output("abort div1 done pulses", p1, 0);
    check_output("abort busy after release", int'(busy4), 0);
    scan_display("abort", 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
